// File: rtl/spram_arbiter.sv
// spram_arbiter: request/acknowledge front end for a single spram instance.
// Serialises a CPU port and a host/loader port onto the RAM's address/data/wren
// and returns the RAM's registered read data with a one-cycle ack pulse.
// Optional feature macro: SPRAM_ARB_HOST_EN. When defined, both ports are
// arbitrated round-robin. When undefined, only the CPU port is served and the
// host outputs are tied low.
module spram_arbiter #(
  parameter int widthad_a = 15,
  parameter int width_a   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [widthad_a-1:0] cpu_addr,
  input  logic [width_a-1:0]   cpu_wdata,
  output logic                 cpu_ack,
  output logic [width_a-1:0]   cpu_rdata,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [widthad_a-1:0] host_addr,
  input  logic [width_a-1:0]   host_wdata,
  output logic                 host_ack,
  output logic [width_a-1:0]   host_rdata,
  output logic [widthad_a-1:0] ram_address,
  output logic [width_a-1:0]   ram_data,
  output logic                 ram_wren,
  input  logic [width_a-1:0]   ram_q
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t               state;
  logic                 op_write;   // op of the access currently in flight
  logic                 cpu_elig;
  logic                 any_elig;
  logic                 win_we;
  logic [widthad_a-1:0] win_addr;
  logic [width_a-1:0]   win_wdata;

  // A port is masked during its own ack cycle, so a requester that has not
  // yet reacted to ack cannot have its old request issued a second time.
  assign cpu_elig = cpu_req & ~cpu_ack;

`ifdef SPRAM_ARB_HOST_EN
  logic host_elig;
  logic pick_host;    // winner of this cycle's IDLE evaluation
  logic owner_host;   // port that owns the access in flight
  logic last_host;    // port granted most recently (round-robin pointer)

  assign host_elig = host_req & ~host_ack;
  // Single eligible port wins; on a tie the port not granted last wins.
  assign pick_host = host_elig & (~cpu_elig | ~last_host);
  assign any_elig  = cpu_elig | host_elig;
  assign win_we    = pick_host ? host_we    : cpu_we;
  assign win_addr  = pick_host ? host_addr  : cpu_addr;
  assign win_wdata = pick_host ? host_wdata : cpu_wdata;
`else
  logic unused_host;

  assign unused_host = ^{host_req, host_we, host_addr, host_wdata};
  assign any_elig    = cpu_elig;
  assign win_we      = cpu_we;
  assign win_addr    = cpu_addr;
  assign win_wdata   = cpu_wdata;
  assign host_ack    = 1'b0;
  assign host_rdata  = '0;
`endif

  // Sequencer: IDLE grants and registers the RAM request, ACCESS lets the RAM
  // act on it at the closing edge, DONE hands ack and read data to the owner.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      op_write    <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
`ifdef SPRAM_ARB_HOST_EN
      host_ack    <= 1'b0;
      host_rdata  <= '0;
      owner_host  <= 1'b0;
      last_host   <= 1'b1;
`endif
    end else begin
      cpu_ack <= 1'b0;
`ifdef SPRAM_ARB_HOST_EN
      host_ack <= 1'b0;
`endif
      case (state)
        IDLE: begin
          ram_wren <= 1'b0;
          if (any_elig) begin
            ram_address <= win_addr;
            ram_data    <= win_wdata;
            ram_wren    <= win_we;
            op_write    <= win_we;
`ifdef SPRAM_ARB_HOST_EN
            owner_host  <= pick_host;
            last_host   <= pick_host;
`endif
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          // The RAM performs the op at the end of this cycle; address holds.
          ram_wren <= 1'b0;
          state    <= DONE;
        end
        DONE: begin
          // ram_q is only meaningful after a read; writes leave rdata alone.
`ifdef SPRAM_ARB_HOST_EN
          host_ack <= owner_host;
          cpu_ack  <= ~owner_host;
          if (!op_write && owner_host) begin
            host_rdata <= ram_q;
          end
          if (!op_write && !owner_host) begin
            cpu_rdata <= ram_q;
          end
`else
          cpu_ack <= 1'b1;
          if (!op_write) begin
            cpu_rdata <= ram_q;
          end
`endif
          state <= IDLE;
        end
        default: begin
          ram_wren <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: randomized and directed bench for spram_arbiter with a
// behavioural RAM and a transaction-level memory scoreboard.
module tb_spram_arbiter;
  localparam int AW = 15;
  localparam int DW = 8;
`ifdef SPRAM_ARB_HOST_EN
  localparam bit HOST_EN = 1'b1;
  localparam int MAX_LAT = 6;   // own ack-cycle mask plus one full access of the other port
`else
  localparam bit HOST_EN = 1'b0;
  localparam int MAX_LAT = 4;   // own ack-cycle mask only
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  spram_arbiter #(.widthad_a(AW), .width_a(DW)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // Behavioural spram: registered read, q holds during writes.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    else          ram_q <= mem[ram_address];
  end

  // Reference memory contents, updated in the order accesses are acknowledged.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit ack_order[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: wren pulse accounting and ack bookkeeping.
  int            wren_cnt = 0, cpu_ack_cnt = 0, host_ack_cnt = 0;
  logic          prev_wren = 1'b0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [DW-1:0] last_wr_data = '0;
  always @(negedge clock) begin
    if (ram_wren) begin
      wren_cnt     <= wren_cnt + 1;
      last_wr_addr <= ram_address;
      last_wr_data <= ram_data;
      check("wren_one_cycle", 32'(prev_wren), 32'(0));
    end
    prev_wren <= ram_wren;
    if (cpu_ack)  cpu_ack_cnt  <= cpu_ack_cnt + 1;
    if (host_ack) host_ack_cnt <= host_ack_cnt + 1;
    if (cpu_ack || host_ack) check("ack_exclusive", 32'(cpu_ack & host_ack), 32'(0));
`ifndef SPRAM_ARB_HOST_EN
    check("host_ack_tied", 32'(host_ack), 32'(0));
    check("host_rdata_tied", 32'(host_rdata), 32'(0));
`endif
  end

  // One access from a port; called and returns at a falling edge.
  task automatic do_access(input bit host, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input bit keep, output int lat);
    logic [DW-1:0] old_rd;
    logic [DW-1:0] rd;
    logic          got;
    old_rd = host ? host_rdata : cpu_rdata;
    if (host) begin
      host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clock);
      lat++;
      got = host ? host_ack : cpu_ack;
    end
    check(host ? "host_ack_seen" : "cpu_ack_seen", 32'(got), 32'(1));
    if (!keep || !got) begin
      if (host) host_req = 1'b0;
      else      cpu_req  = 1'b0;
    end
    if (got) begin
      rd = host ? host_rdata : cpu_rdata;
      ack_order.push_back(host);
      if (we) begin
        ref_mem[addr] = wdata;
        check("rdata_hold_on_write", 32'(rd), 32'(old_rd));
      end else begin
        check("read_data", 32'(rd), 32'(ref_mem[addr]));
      end
      $display("[TB] %s %s addr=0x%04h data=0x%02h lat=%0d", host ? "host" : "cpu ",
               we ? "wr" : "rd", addr, we ? wdata : rd, lat);
    end
  endtask

  task automatic rand_port(input bit host, input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      bit            keep;
      bit            we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      keep = (i < n - 1) && ($urandom_range(0, 1) == 1);
      we   = 1'($urandom_range(0, 1));
      a    = AW'($urandom_range(0, 15));
      d    = DW'($urandom);
      do_access(host, we, a, d, keep, lat);
      check("latency_bound", 32'(lat <= MAX_LAT), 32'(1));
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge clock);
    end
  endtask

  task automatic do_reset();
    cpu_req = 1'b0;
    host_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int lat, lat_c, lat_h, wc, c0, a0;
    repeat (3) @(negedge clock);
    check("rst_ram_wren", 32'(ram_wren), 32'(0));
    check("rst_ram_address", 32'(ram_address), 32'(0));
    check("rst_ram_data", 32'(ram_data), 32'(0));
    check("rst_cpu_ack", 32'(cpu_ack), 32'(0));
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
    check("rst_host_ack", 32'(host_ack), 32'(0));
    check("rst_host_rdata", 32'(host_rdata), 32'(0));
    reset = 1'b0;
    @(negedge clock);

    // Known contents for every address the bench reads.
    for (int a = 0; a < 16; a++) do_access(1'b0, 1'b1, AW'(a), DW'(a * 7 + 'h30), 1'b0, lat);
    do_access(1'b0, 1'b1, 15'h0001, 8'h11, 1'b0, lat);
    do_access(HOST_EN, 1'b1, 15'h7FFF, 8'h22, 1'b0, lat);
    do_access(1'b0, 1'b1, 15'h0100, 8'h3C, 1'b0, lat);

    // CPU write then read of 0x1234.
    @(negedge clock);
    wc = wren_cnt;
    do_access(1'b0, 1'b1, 15'h1234, 8'h5A, 1'b0, lat);
    @(negedge clock);
    check("t1_wren_pulses", 32'(wren_cnt - wc), 32'(1));
    check("t1_wr_addr", 32'(last_wr_addr), 32'h1234);
    check("t1_wr_data", 32'(last_wr_data), 32'h5A);
    do_access(1'b0, 1'b0, 15'h1234, 8'h00, 1'b0, lat);
    check("t1_read_latency", 32'(lat), 32'(3));
    check("t1_read_data", 32'(cpu_rdata), 32'h5A);

    // CPU back-to-back reads of 0x0000..0x0003 with req held.
    @(negedge clock);
    c0 = cpu_ack_cnt;
    for (int a = 0; a < 4; a++) do_access(1'b0, 1'b0, AW'(a), 8'h00, a < 3, lat);
    repeat (8) @(negedge clock);
    check("t3_ack_count", 32'(cpu_ack_cnt - c0), 32'(4));

    // Reset during the ACCESS cycle of a write of 0xFF to 0x0100.
    @(negedge clock);
    if (HOST_EN) begin
      host_req = 1'b1; host_we = 1'b1; host_addr = 15'h0100; host_wdata = 8'hFF;
    end else begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0100; cpu_wdata = 8'hFF;
    end
    @(negedge clock);
    check("t5_wren_in_access", 32'(ram_wren), 32'(1));
    check("t5_addr_in_access", 32'(ram_address), 32'h0100);
    a0 = HOST_EN ? host_ack_cnt : cpu_ack_cnt;
    reset = 1'b1;
    #1;
    check("t5_wren_drop", 32'(ram_wren), 32'(0));
    cpu_req = 1'b0;
    host_req = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("t5_no_ack", 32'(HOST_EN ? host_ack_cnt - a0 : cpu_ack_cnt - a0), 32'(0));
    do_access(1'b0, 1'b0, 15'h0100, 8'h00, 1'b0, lat);
    check("t5_prior_contents", 32'(cpu_rdata), 32'h3C);

`ifdef SPRAM_ARB_HOST_EN
    // Simultaneous reads right after reset: CPU wins the first tie.
    do_reset();
    fork
      do_access(1'b0, 1'b0, 15'h0001, 8'h00, 1'b0, lat_c);
      do_access(1'b1, 1'b0, 15'h7FFF, 8'h00, 1'b0, lat_h);
    join
    check("t2_cpu_latency", 32'(lat_c), 32'(3));
    check("t2_host_latency", 32'(lat_h), 32'(6));
    check("t2_cpu_rdata", 32'(cpu_rdata), 32'h11);
    check("t2_host_rdata", 32'(host_rdata), 32'h22);

    // Both ports hold req continuously: grants alternate starting with CPU.
    do_reset();
    ack_order.delete();
    fork
      begin
        int l1;
        for (int i = 0; i < 4; i++) do_access(1'b0, 1'b0, AW'($urandom_range(0, 15)), 8'h00, i < 3, l1);
      end
      begin
        int l2;
        for (int i = 0; i < 4; i++) do_access(1'b1, 1'b0, AW'($urandom_range(0, 15)), 8'h00, i < 3, l2);
      end
    join
    check("t4_grant_count", 32'(ack_order.size()), 32'(8));
    for (int i = 0; i < ack_order.size(); i++) check("t4_alternate", 32'(ack_order[i]), 32'(i % 2));

    // Randomized traffic on both ports.
    @(negedge clock);
    fork
      rand_port(1'b0, 40);
      rand_port(1'b1, 40);
    join
`else
    // Host port held requesting a write throughout; it must be ignored.
    host_req = 1'b1; host_we = 1'b1; host_addr = 15'h0005; host_wdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      do_access(1'b0, 1'b1, AW'(32 + i), DW'($urandom), 1'b0, lat);
      check("t6_write_latency", 32'(lat), 32'(3));
      @(negedge clock);
      do_access(1'b0, 1'b0, AW'(32 + i), 8'h00, 1'b0, lat);
      check("t6_read_latency", 32'(lat), 32'(3));
    end
    @(negedge clock);
    fork
      rand_port(1'b0, 60);
      repeat (200) begin
        @(negedge clock);
        host_req = 1'b1; host_we = 1'($urandom_range(0, 1));
        host_addr = AW'($urandom_range(0, 15)); host_wdata = DW'($urandom);
      end
    join
`endif

    repeat (4) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
